mc_datapath: RTL and testbench
==============================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC at reset.
REQ-002 Parameter MEM_TIMEOUT, default 16, max wait cycles per memory request before bus error; 0 disables timeout.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  memory request valid.
REQ-006 mem_we  output  1  write request when mem_req=1.
REQ-007 mem_addr  output  32  byte address of request.
REQ-008 mem_wdata  output  32  store data.
REQ-009 mem_rdata  input  32  fetch/load data, valid when mem_ready=1.
REQ-010 mem_ready  input  1  request completes in the cycle mem_req=1 and mem_ready=1.
REQ-011 pc_out  output  32  current PC, byte address.
REQ-012 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-013 illegal  output  1  sticky flag, unsupported opcode/funct seen.
REQ-014 bus_err  output  1  sticky flag, memory timeout occurred; core halted.

Function
REQ-015 Shall be a multicycle MIPS core: one unified memory port, internal control FSM, 32x32 register file, one ALU shared for PC+4, branch target, and execute.
REQ-016 Supported: R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), lw, sw, beq, addi, j; any other opcode/funct is illegal.
REQ-017 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=PC; hold until mem_ready; on ready IR<=mem_rdata, PC<=PC+4, go DECODE.
REQ-019 DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(signext(imm)<<2); go by opcode: lw/sw->MEMADR, R->EXEC, addi->ADDIEX, beq->BRANCH, j->JUMP, illegal->FETCH with illegal<=1, no register/memory side effect, no instr_done.
REQ-020 MEMADR: ALUOut<=A+signext(imm); lw->MEMRD, sw->MEMWR.
REQ-021 MEMRD: mem_req=1, mem_we=0, mem_addr=ALUOut; on ready MDR<=mem_rdata, go MEMWB.
REQ-022 MEMWB: rf[rt]<=MDR, instr_done=1, go FETCH.
REQ-023 MEMWR: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B; on ready instr_done=1, go FETCH.
REQ-024 EXEC: ALUOut<=A op B per funct; ALUWB: rf[rd]<=ALUOut, instr_done=1, go FETCH.
REQ-025 ADDIEX: ALUOut<=A+signext(imm); ADDIWB: rf[rt]<=ALUOut, instr_done=1, go FETCH.
REQ-026 BRANCH: if A==B then PC<=ALUOut; instr_done=1; go FETCH.
REQ-027 JUMP: PC<={PC[31:28], instr[25:0], 2'b00} using the already-incremented PC; instr_done=1; go FETCH.
REQ-028 Arithmetic is 32-bit modulo 2^32; overflow ignored; slt signed; register 0 reads 0 and writes to it are discarded.
REQ-029 mem_addr, mem_we, mem_wdata shall be stable while mem_req=1 and mem_ready=0; mem_req=0 outside FETCH/MEMRD/MEMWR; mem_ready ignored when mem_req=0.
REQ-030 Wait counter clears on entry to each request state, increments per waiting cycle; if MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT without ready, bus_err<=1, go HALT.
REQ-031 HALT: terminal until reset; mem_req=0, no register or PC updates.
REQ-032 pc_out shall equal PC register at all times; PC changes only in FETCH (on ready), BRANCH (taken), JUMP.

Reset
REQ-033 rst=0 asynchronously forces state FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, wait counter=0, illegal=0, bus_err=0, instr_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-034 Register file contents are not reset.
REQ-035 Reset mid-request abandons the transaction; first request after release is a fetch at RESET_PC.

Verification
REQ-036 Zero-wait memory; addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x40($0) -> write 12 to addr 0x40, four instr_done pulses, 4+4+4+4 cycles each.
REQ-037 lw from 0x40 with mem_ready delayed 3 cycles -> request signals stable during wait, rt gets 12, MEMRD lasts 4 cycles.
REQ-038 beq $1,$1,-1 at 0x10 -> PC returns to 0x10; beq not-taken -> PC=0x14; j 0x100 at 0x20 -> PC=0x400.
REQ-039 Opcode 0x3F -> illegal=1, no write, next fetch at PC+4; add $0,$1,$2 -> $0 still reads 0.
REQ-040 mem_ready held 0 with MEM_TIMEOUT=16 -> bus_err=1 after 16 wait cycles, mem_req=0 thereafter; rst pulse clears and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mc_datapath.sv
// Multicycle MIPS subset core: one shared ALU, a unified memory port and a 32x32 register file.
// Each memory request waits for mem_ready; a bounded wait ends in HALT with bus_err set.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4 on ready
// DECODE  | read rs/rt, precompute branch target, dispatch on opcode
// MEMADR  | effective address A + signext(imm)
// MEMRD   | load request at ALUOut
// MEMWB   | rt <= MDR, retire
// MEMWR   | store request of B at ALUOut, retire on ready
// EXEC    | R-type ALU operation
// ALUWB   | rd <= ALUOut, retire
// ADDIEX  | A + signext(imm)
// ADDIWB  | rt <= ALUOut, retire
// BRANCH  | beq compare, PC <= target if equal, retire
// JUMP    | PC <= {PC[31:28], index, 00}, retire
// HALT    | bus timeout, frozen until reset
module mc_datapath #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic        instr_done,
  output logic        illegal,
  output logic        bus_err
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_out_q, mdr_q;
  logic [31:0] wait_cnt_q;
  logic        illegal_q, bus_err_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx;
  logic        op_legal;

  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op, funct_op;

  logic [31:0] rf [32];
  logic [31:0] rs_val, rt_val;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  logic        req_c, we_c, done_c, timeout;
  logic [31:0] addr_c, wdata_c;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};

  assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];

  always_comb begin
    funct_op = ALU_ADD;
    op_legal = 1'b1;
    case (funct)
      6'h20:   funct_op = ALU_ADD;
      6'h22:   funct_op = ALU_SUB;
      6'h24:   funct_op = ALU_AND;
      6'h25:   funct_op = ALU_OR;
      6'h2A:   funct_op = ALU_SLT;
      default: op_legal = (opcode != OP_RTYPE);
    endcase
    if (!(opcode inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW})) op_legal = 1'b0;
  end

  // Single ALU serves PC+4, branch target, address, execute and beq compare
  always_comb begin
    alu_a  = pc_q;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    case (state_q)
      S_DECODE:          alu_b = {imm_sx[29:0], 2'b00};
      S_MEMADR, S_ADDIEX: begin
        alu_a = a_q;
        alu_b = imm_sx;
      end
      S_EXEC: begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = funct_op;
      end
      S_BRANCH: begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_y = alu_a + alu_b;
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: ;
    endcase
  end

  // Timeout fires on the MEM_TIMEOUT-th consecutive cycle without ready
  assign timeout = req_c && !mem_ready && (MEM_TIMEOUT != 0) &&
                   (wait_cnt_q == MEM_TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = 32'd0;
    wdata_c = 32'd0;
    done_c  = 1'b0;
    rf_we   = 1'b0;
    rf_wa   = rt;
    rf_wd   = alu_out_q;
    case (state_q)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc_q;
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: begin
        if (!op_legal) state_d = S_FETCH;
        else begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_EXEC;
          endcase
        end
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        req_c  = 1'b1;
        addr_c = alu_out_q;
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_HALT;
      end
      S_MEMWB: begin
        rf_we   = 1'b1;
        rf_wd   = mdr_q;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        req_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = alu_out_q;
        wdata_c = b_q;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) state_d = S_HALT;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB: begin
        rf_we   = 1'b1;
        rf_wa   = rd;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin
        rf_we   = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH, S_JUMP: begin
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      alu_out_q  <= 32'd0;
      mdr_q      <= 32'd0;
      wait_cnt_q <= 32'd0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_c && !mem_ready && !timeout) wait_cnt_q <= wait_cnt_q + 32'd1;
      else                                 wait_cnt_q <= 32'd0;
      if (timeout) bus_err_q <= 1'b1;
      case (state_q)
        S_FETCH: if (mem_ready) begin
          ir_q <= mem_rdata;
          pc_q <= alu_y;
        end
        S_DECODE: begin
          a_q       <= rs_val;
          b_q       <= rt_val;
          alu_out_q <= alu_y;
          if (!op_legal) illegal_q <= 1'b1;
        end
        S_MEMADR, S_EXEC, S_ADDIEX: alu_out_q <= alu_y;
        S_MEMRD:  if (mem_ready) mdr_q <= mem_rdata;
        S_BRANCH: if (alu_y == 32'd0) pc_q <= alu_out_q;
        S_JUMP:   pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Register file is deliberately not reset; $0 writes are dropped here
  always_ff @(posedge clk) begin
    if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
  end

  // Reset forces the request outputs low even though the state reads FETCH
  assign mem_req    = req_c & rst;
  assign mem_we     = we_c & rst;
  assign mem_addr   = rst ? addr_c : 32'd0;
  assign mem_wdata  = rst ? wdata_c : 32'd0;
  assign instr_done = done_c & rst;
  assign pc_out     = pc_q;
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: word memory model with programmable ready latency,
// an ALU vector table plus hand sequences for timing, branches, illegal ops and timeout.
module tb_mc_datapath;

  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready, instr_done, illegal, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  always #5 clk = ~clk;

  mc_datapath dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_out(pc_out),
    .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
  );

  logic [31:0] mem [1024];
  int unsigned lat = 0;
  bit          stuck = 1'b0;
  int unsigned req_wait = 0;
  bit          ld_en = 1'b0;
  logic [31:0] ld_addr = 32'd0, ld_data = 32'd0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = 32'd0, last_wd = 32'd0;
  int unsigned cyc = 0;

  assign mem_ready = mem_req && !stuck && (req_wait >= lat);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en) mem[ld_addr[11:2]] <= ld_data;
    else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wdata;
    end
    if (!mem_req || mem_ready) req_wait <= 0;
    else                       req_wait <= req_wait + 1;
  end

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned start = 0;
  int          done_cyc [8];
  logic [31:0] pc_after [8];

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_ill;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b, required %b", nm, act, exp);
    end
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check1("rst_done", instr_done, 1'b0);
    check1("rst_illegal", illegal, 1'b0);
    check1("rst_bus_err", bus_err, 1'b0);
    rst   = 1'b1;
    start = cyc;
  endtask

  // Records the relative cycle of each retire pulse and the PC one cycle later
  task automatic run_dones(input int n, input int budget);
    int got = 0;
    int t = 0;
    while (got < n && t < budget) begin
      @(negedge clk);
      t++;
      if (instr_done) begin
        done_cyc[got] = int'(cyc - start);
        @(negedge clk);
        t++;
        pc_after[got] = pc_out;
        got++;
      end
    end
    check("done_count", got, n);
  endtask

  task automatic wait_wr(input int target, input int budget);
    int t = 0;
    while (wr_cnt < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check1("wr_seen", wr_cnt >= target, 1'b1);
  endtask

  localparam logic [31:0] LOOP = 32'h1000_FFFF;

  initial begin
    int w0, dur, found;
    int unsigned c0;
    bit ok;
    logic [31:0] exp_pc [7];

    vecs[0] = '{6'h20, 32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1] = '{6'h20, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[2] = '{6'h22, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
    vecs[3] = '{6'h24, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0};
    vecs[4] = '{6'h25, 32'h0F0F_0000,  32'h0000_00FF,  32'h0F0F_00FF,  1'b0};
    vecs[5] = '{6'h2A, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    vecs[6] = '{6'h2A, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[7] = '{6'h2A, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0};
    vecs[8] = '{6'h2A, 32'd5,          32'd5,          32'd0,          1'b0};
    vecs[9] = '{6'h21, 32'd5,          32'd7,          32'd0,          1'b1};

    // addi/addi/add/sw with zero-wait memory, 4 cycles each
    hold_reset();
    ld(32'h00, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5));
    ld(32'h04, enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7));
    ld(32'h08, enc_r(5'd1, 5'd2, 5'd3, 6'h20));
    ld(32'h0C, enc_i(OP_SW, 5'd0, 5'd3, 16'h0040));
    ld(32'h10, LOOP);
    ld(32'h40, 32'd0);
    w0 = wr_cnt;
    release_rst();
    run_dones(4, 40);
    for (int i = 0; i < 4; i++) check("s1_done_cycle", done_cyc[i], 3 + 4 * i);
    check("s1_wr_count", wr_cnt - w0, 1);
    check("s1_wr_addr", last_wa, 32'h40);
    check("s1_wr_data", last_wd, 32'd12);
    check("s1_mem40", rd_mem(32'h40), 32'd12);
    check1("s1_illegal", illegal, 1'b0);

    // lw with ready delayed 3 cycles, then store the loaded value back
    hold_reset();
    lat = 3;
    ld(32'h00, enc_i(OP_LW, 5'd0, 5'd5, 16'h0040));
    ld(32'h04, enc_i(OP_SW, 5'd0, 5'd5, 16'h0044));
    ld(32'h08, LOOP);
    ld(32'h40, 32'd12);
    ld(32'h44, 32'd0);
    w0 = wr_cnt;
    release_rst();
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 32'h40) found = 1;
    end
    check("lw_req_seen", found, 1);
    dur = 0;
    ok  = 1'b1;
    for (int t = 0; t < 20; t++) begin
      dur++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) ok = 1'b0;
      if (mem_ready) break;
      @(negedge clk);
    end
    check1("lw_req_stable", ok, 1'b1);
    check("lw_memrd_cycles", dur, 4);
    wait_wr(w0 + 1, 60);
    check("lw_wb_addr", last_wa, 32'h44);
    check("lw_wb_data", last_wd, 32'd12);
    lat = 0;

    // ALU vector table: $3 cleared, operands loaded, op applied, result stored at 0x88
    foreach (vecs[i]) begin
      hold_reset();
      ld(32'h00, enc_r(5'd0, 5'd0, 5'd3, 6'h20));
      ld(32'h04, enc_i(OP_LW, 5'd0, 5'd1, 16'h0080));
      ld(32'h08, enc_i(OP_LW, 5'd0, 5'd2, 16'h0084));
      ld(32'h0C, enc_r(5'd1, 5'd2, 5'd3, vecs[i].funct));
      ld(32'h10, enc_i(OP_SW, 5'd0, 5'd3, 16'h0088));
      ld(32'h14, LOOP);
      ld(32'h80, vecs[i].a);
      ld(32'h84, vecs[i].b);
      ld(32'h88, 32'h5A5A_5A5A);
      release_rst();
      repeat (30) @(negedge clk);
      check($sformatf("alu_vec%0d_result", i), rd_mem(32'h88), vecs[i].exp);
      check1($sformatf("alu_vec%0d_illegal", i), illegal, vecs[i].exp_ill);
    end

    // jumps and branches, observing the PC after each retire
    hold_reset();
    ld(32'h000, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1));
    ld(32'h004, enc_i(OP_ADDI, 5'd0, 5'd2, 16'd2));
    ld(32'h008, {OP_J, 26'h4});
    ld(32'h00C, 32'hFC00_0000);
    ld(32'h010, enc_i(OP_BEQ, 5'd1, 5'd2, 16'd3));
    ld(32'h014, {OP_J, 26'h8});
    ld(32'h020, {OP_J, 26'h100});
    ld(32'h400, enc_i(OP_BEQ, 5'd1, 5'd1, 16'hFFFF));
    exp_pc = '{32'h04, 32'h08, 32'h10, 32'h14, 32'h20, 32'h400, 32'h400};
    release_rst();
    run_dones(7, 80);
    for (int i = 0; i < 7; i++) check($sformatf("br_pc%0d", i), pc_after[i], exp_pc[i]);
    check1("br_illegal", illegal, 1'b0);

    // illegal opcode then $0 write attempt
    hold_reset();
    ld(32'h00, 32'hFC00_0000);
    ld(32'h04, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd3));
    ld(32'h08, enc_r(5'd1, 5'd1, 5'd0, 6'h20));
    ld(32'h0C, enc_i(OP_SW, 5'd0, 5'd0, 16'h0048));
    ld(32'h10, enc_i(OP_SW, 5'd0, 5'd1, 16'h004C));
    ld(32'h14, LOOP);
    ld(32'h48, 32'hDEAD_BEEF);
    ld(32'h4C, 32'hDEAD_BEEF);
    w0 = wr_cnt;
    release_rst();
    run_dones(4, 60);
    check("ill_first_done_cycle", done_cyc[0], 5);
    check("ill_next_pc", pc_after[0], 32'h08);
    check1("ill_flag", illegal, 1'b1);
    check("ill_wr_count", wr_cnt - w0, 2);
    check("ill_r0_reads_zero", rd_mem(32'h48), 32'd0);
    check("ill_r1_value", rd_mem(32'h4C), 32'd3);

    // fetch timeout, halt, async reset and restart at the reset PC
    hold_reset();
    ld(32'h00, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1));
    ld(32'h04, enc_i(OP_ADDI, 5'd0, 5'd2, 16'd2));
    ld(32'h08, LOOP);
    release_rst();
    run_dones(1, 20);
    stuck = 1'b1;
    c0 = cyc;
    check1("to_fetch_req", mem_req, 1'b1);
    check("to_fetch_addr", mem_addr, 32'h04);
    found = -1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus_err) begin
        found = int'(cyc - c0);
        break;
      end
    end
    check("to_cycles", found, 16);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || instr_done !== 1'b0) ok = 1'b0;
    end
    check1("to_halt_quiet", ok, 1'b1);
    check("to_halt_pc", pc_out, 32'h04);
    check1("to_bus_err_sticky", bus_err, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check1("async_bus_err", bus_err, 1'b0);
    check("async_pc", pc_out, 32'd0);
    check1("async_mem_req", mem_req, 1'b0);
    stuck = 1'b0;
    release_rst();
    #1;
    check1("restart_req", mem_req, 1'b1);
    check1("restart_we", mem_we, 1'b0);
    check("restart_addr", mem_addr, 32'd0);
    run_dones(2, 30);
    check("restart_pc0", pc_after[0], 32'h04);
    check("restart_pc1", pc_after[1], 32'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
